// File: rtl/wb_regfile_dual_pkg.sv
// Shared definitions for the dual-issue write-back stage and register file.
// Optional feature macro: WB_BYPASS_EN (write-through reads), handled in the top.
package wb_regfile_dual_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    // Source of a lane's write-back value.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    // True when a destination index names a real, writable register.
    function automatic logic is_writable_idx(input logic [REG_IDX_W-1:0] idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_regfile_dual_lane_sel.sv
// Per-lane write-back select: picks load data or ALU result and qualifies
// the raw write enable against the hardwired zero register.
module wb_lane_sel #(
    parameter int XLEN = wb_regfile_dual_pkg::XLEN
) (
    input  logic                                     wb_sel,
    input  logic                                     reg_wr,
    input  logic [XLEN-1:0]                          do_wb,
    input  logic [XLEN-1:0]                          alu_wb,
    input  logic [wb_regfile_dual_pkg::REG_IDX_W-1:0] dst_idx,
    output logic [XLEN-1:0]                          wd_wb,
    output logic                                     we_raw
);
    import wb_regfile_dual_pkg::*;

    wb_src_e src;

    assign src = wb_src_e'(wb_sel);

    // Value mux and raw enable; both purely combinational.
    always_comb begin
        wd_wb  = (src == WB_SRC_MEM) ? do_wb : alu_wb;
        we_raw = reg_wr & is_writable_idx(dst_idx);
    end

endmodule

// File: rtl/wb_regfile_dual.sv
// Dual-lane write-back stage and 32 x XLEN architectural register file.
// Lane 2 is the younger instruction and wins same-destination conflicts.
// Optional macro WB_BYPASS_EN: reads see a same-cycle write (write-through).
module wb_regfile_dual #(
    parameter int XLEN = wb_regfile_dual_pkg::XLEN,
    parameter int NREG = wb_regfile_dual_pkg::NREG
) (
    input  logic                                     reloj,
    input  logic                                     resetWB,
    input  logic                                     DIR_WB1,
    input  logic                                     DIR_WB2,
    input  logic                                     REG_WR1,
    input  logic                                     REG_WR2,
    input  logic [XLEN-1:0]                          DO_wb1,
    input  logic [XLEN-1:0]                          DO_wb2,
    input  logic [XLEN-1:0]                          DIR_wb1,
    input  logic [XLEN-1:0]                          DIR_wb2,
    input  logic [wb_regfile_dual_pkg::REG_IDX_W-1:0] Y_MUX_wb1,
    input  logic [wb_regfile_dual_pkg::REG_IDX_W-1:0] Y_MUX_wb2,
    input  logic [wb_regfile_dual_pkg::REG_IDX_W-1:0] RA1,
    input  logic [wb_regfile_dual_pkg::REG_IDX_W-1:0] RA2,
    input  logic [wb_regfile_dual_pkg::REG_IDX_W-1:0] RA3,
    input  logic [wb_regfile_dual_pkg::REG_IDX_W-1:0] RA4,
    output logic [XLEN-1:0]                          RD1,
    output logic [XLEN-1:0]                          RD2,
    output logic [XLEN-1:0]                          RD3,
    output logic [XLEN-1:0]                          RD4,
    output logic [XLEN-1:0]                          WD_wb1,
    output logic [XLEN-1:0]                          WD_wb2,
    output logic                                     WE_eff1,
    output logic                                     WE_eff2
);
    import wb_regfile_dual_pkg::*;

    logic                 we_raw1;
    logic                 we_raw2;
    logic                 same_dst;
    logic [XLEN-1:0]      regs [NREG];
    logic [REG_IDX_W-1:0] ra_arr [4];
    logic [XLEN-1:0]      rd_arr [4];

    wb_lane_sel #(.XLEN(XLEN)) u_lane1 (
        .wb_sel  (DIR_WB1),
        .reg_wr  (REG_WR1),
        .do_wb   (DO_wb1),
        .alu_wb  (DIR_wb1),
        .dst_idx (Y_MUX_wb1),
        .wd_wb   (WD_wb1),
        .we_raw  (we_raw1)
    );

    wb_lane_sel #(.XLEN(XLEN)) u_lane2 (
        .wb_sel  (DIR_WB2),
        .reg_wr  (REG_WR2),
        .do_wb   (DO_wb2),
        .alu_wb  (DIR_wb2),
        .dst_idx (Y_MUX_wb2),
        .wd_wb   (WD_wb2),
        .we_raw  (we_raw2)
    );

    // Cross-lane conflict: the younger lane 2 suppresses lane 1 on a shared destination.
    always_comb begin
        same_dst = (Y_MUX_wb1 == Y_MUX_wb2);
        WE_eff2  = we_raw2;
        WE_eff1  = we_raw1 & ~(we_raw2 & same_dst);
    end

    // Register array: synchronous clear has priority over both lane writes.
    // Index 0 is never written because both enables exclude it.
    always_ff @(posedge reloj) begin
        if (resetWB) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (WE_eff1) begin
                regs[Y_MUX_wb1] <= WD_wb1;
            end
            if (WE_eff2) begin
                regs[Y_MUX_wb2] <= WD_wb2;
            end
        end
    end

    assign ra_arr[0] = RA1;
    assign ra_arr[1] = RA2;
    assign ra_arr[2] = RA3;
    assign ra_arr[3] = RA4;

    // Asynchronous read ports; optional write-through with lane 2 checked last so it wins.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_arr[k] = regs[ra_arr[k]];
`ifdef WB_BYPASS_EN
            if (WE_eff1 && (Y_MUX_wb1 == ra_arr[k])) begin
                rd_arr[k] = WD_wb1;
            end
            if (WE_eff2 && (Y_MUX_wb2 == ra_arr[k])) begin
                rd_arr[k] = WD_wb2;
            end
`endif
            if (ra_arr[k] == REG_ZERO) begin
                rd_arr[k] = '0;
            end
        end
    end

    assign RD1 = rd_arr[0];
    assign RD2 = rd_arr[1];
    assign RD3 = rd_arr[2];
    assign RD4 = rd_arr[3];

endmodule

// File: tb/tb_wb_regfile_dual.sv
// Directed bench for wb_regfile_dual: stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_wb_regfile_dual;

    logic        reloj = 1'b0;
    logic        resetWB;
    logic        DIR_WB1, DIR_WB2, REG_WR1, REG_WR2;
    logic [31:0] DO_wb1, DO_wb2, DIR_wb1, DIR_wb2;
    logic [4:0]  Y_MUX_wb1, Y_MUX_wb2, RA1, RA2, RA3, RA4;
    logic [31:0] RD1, RD2, RD3, RD4, WD_wb1, WD_wb2;
    logic        WE_eff1, WE_eff2;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        int          id;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       total = 0;
    int       bad   = 0;

    always #5 reloj = ~reloj;

    wb_regfile_dual dut (
        .reloj     (reloj),
        .resetWB   (resetWB),
        .DIR_WB1   (DIR_WB1),
        .DIR_WB2   (DIR_WB2),
        .REG_WR1   (REG_WR1),
        .REG_WR2   (REG_WR2),
        .DO_wb1    (DO_wb1),
        .DO_wb2    (DO_wb2),
        .DIR_wb1   (DIR_wb1),
        .DIR_wb2   (DIR_wb2),
        .Y_MUX_wb1 (Y_MUX_wb1),
        .Y_MUX_wb2 (Y_MUX_wb2),
        .RA1       (RA1),
        .RA2       (RA2),
        .RA3       (RA3),
        .RA4       (RA4),
        .RD1       (RD1),
        .RD2       (RD2),
        .RD3       (RD3),
        .RD4       (RD4),
        .WD_wb1    (WD_wb1),
        .WD_wb2    (WD_wb2),
        .WE_eff1   (WE_eff1),
        .WE_eff2   (WE_eff2)
    );

    function automatic string sel_name(input int sel);
        case (sel)
            0: return "RD1";
            1: return "RD2";
            2: return "RD3";
            3: return "RD4";
            4: return "WD_wb1";
            5: return "WD_wb2";
            6: return "WE_eff1";
            default: return "WE_eff2";
        endcase
    endfunction

    function automatic logic [31:0] sel_value(input int sel);
        case (sel)
            0: return RD1;
            1: return RD2;
            2: return RD3;
            3: return RD4;
            4: return WD_wb1;
            5: return WD_wb2;
            6: return {31'd0, WE_eff1};
            default: return {31'd0, WE_eff2};
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [31:0] exp, input int id);
        sb_item_t it;
        it.sel = sel;
        it.exp = exp;
        it.id  = id;
        sb_q.push_back(it);
    endtask

    // Monitor: drains the scoreboard mid-cycle, away from the active edge.
    always @(negedge reloj) begin
        while (sb_q.size() > 0) begin
            sb_item_t it;
            logic [31:0] act;
            it  = sb_q.pop_front();
            act = sel_value(it.sel);
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL chk%0d %s: got %08h want %08h", it.id, sel_name(it.sel), act, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic idle_lanes();
        REG_WR1 = 1'b0; REG_WR2 = 1'b0;
        DIR_WB1 = 1'b0; DIR_WB2 = 1'b0;
        DO_wb1 = '0; DO_wb2 = '0; DIR_wb1 = '0; DIR_wb2 = '0;
        Y_MUX_wb1 = '0; Y_MUX_wb2 = '0;
    endtask

    logic [31:0] same_cycle_exp;
    logic [31:0] reset_cycle_exp;

    initial begin
        resetWB = 1'b1;
        idle_lanes();
        RA1 = '0; RA2 = '0; RA3 = '0; RA4 = '0;
`ifdef WB_BYPASS_EN
        same_cycle_exp  = 32'h42;
        reset_cycle_exp = 32'h77;
`else
        same_cycle_exp  = 32'h0;
        reset_cycle_exp = 32'h0;
`endif
        step();
        step();

        // Reset state: arbitrary registers read zero.
        resetWB = 1'b0;
        RA1 = 5'd31; RA2 = 5'd1; RA3 = 5'd17; RA4 = 5'd0;
        expect_val(0, 32'h0, 1);
        expect_val(1, 32'h0, 2);
        expect_val(2, 32'h0, 3);
        expect_val(3, 32'h0, 4);

        // r5 = 0x0A via ALU path, then reset clears it.
        step();
        REG_WR1 = 1'b1; DIR_WB1 = 1'b0; DIR_wb1 = 32'h0A; DO_wb1 = 32'hBAD0BAD0; Y_MUX_wb1 = 5'd5;
        expect_val(4, 32'h0A, 5);
        step();
        idle_lanes();
        RA1 = 5'd5;
        expect_val(0, 32'h0A, 6);
        step();
        resetWB = 1'b1;
        step();
        resetWB = 1'b0;
        expect_val(0, 32'h0, 7);

        // Basic commit: lane 1 load data to r3, lane 2 ALU result to r4.
        step();
        REG_WR1 = 1'b1; DIR_WB1 = 1'b1; DO_wb1 = 32'hDEADBEEF; DIR_wb1 = 32'h1; Y_MUX_wb1 = 5'd3;
        REG_WR2 = 1'b1; DIR_WB2 = 1'b0; DO_wb2 = 32'h12345678; DIR_wb2 = 32'h55; Y_MUX_wb2 = 5'd4;
        expect_val(4, 32'hDEADBEEF, 8);
        expect_val(5, 32'h55, 9);
        expect_val(6, 32'h1, 10);
        expect_val(7, 32'h1, 11);
        step();
        // Lane 2 load path to r6 while r3/r4 are read back.
        REG_WR1 = 1'b0;
        REG_WR2 = 1'b1; DIR_WB2 = 1'b1; DO_wb2 = 32'hCAFEF00D; DIR_wb2 = 32'h9; Y_MUX_wb2 = 5'd6;
        RA1 = 5'd3; RA3 = 5'd4;
        expect_val(0, 32'hDEADBEEF, 12);
        expect_val(2, 32'h55, 13);
        expect_val(5, 32'hCAFEF00D, 14);
        step();
        idle_lanes();
        RA2 = 5'd6;
        expect_val(1, 32'hCAFEF00D, 15);

        // Conflict on r7: lane 2 wins.
        step();
        REG_WR1 = 1'b1; DIR_WB1 = 1'b0; DIR_wb1 = 32'h111; Y_MUX_wb1 = 5'd7;
        REG_WR2 = 1'b1; DIR_WB2 = 1'b0; DIR_wb2 = 32'h222; Y_MUX_wb2 = 5'd7;
        expect_val(6, 32'h0, 16);
        expect_val(7, 32'h1, 17);
        step();
        idle_lanes();
        RA1 = 5'd7;
        expect_val(0, 32'h222, 18);

        // Same index but lane 2 idle: lane 1 is not suppressed.
        step();
        REG_WR1 = 1'b1; DIR_WB1 = 1'b0; DIR_wb1 = 32'h333; Y_MUX_wb1 = 5'd7;
        REG_WR2 = 1'b0; DIR_wb2 = 32'h444; Y_MUX_wb2 = 5'd7;
        expect_val(6, 32'h1, 19);
        expect_val(7, 32'h0, 20);
        step();
        idle_lanes();
        expect_val(0, 32'h333, 21);

        // Zero register: writes to index 0 are disabled and reads stay zero.
        step();
        REG_WR1 = 1'b1; DIR_WB1 = 1'b0; DIR_wb1 = 32'hA5A5A5A5; Y_MUX_wb1 = 5'd0;
        REG_WR2 = 1'b1; DIR_WB2 = 1'b0; DIR_wb2 = 32'hFFFFFFFF; Y_MUX_wb2 = 5'd0;
        RA4 = 5'd0;
        expect_val(6, 32'h0, 22);
        expect_val(7, 32'h0, 23);
        expect_val(3, 32'h0, 24);
        step();
        idle_lanes();
        expect_val(3, 32'h0, 25);

        // Same-cycle read of the index being written.
        step();
        REG_WR1 = 1'b1; DIR_WB1 = 1'b0; DIR_wb1 = 32'h42; Y_MUX_wb1 = 5'd9;
        RA2 = 5'd9;
        expect_val(1, same_cycle_exp, 26);
        step();
        idle_lanes();
        expect_val(1, 32'h42, 27);

        // Write during reset is lost; repeated write one cycle later lands.
        step();
        resetWB = 1'b1;
        REG_WR1 = 1'b1; DIR_WB1 = 1'b0; DIR_wb1 = 32'h77; Y_MUX_wb1 = 5'd2;
        step();
        resetWB = 1'b0;
        RA1 = 5'd2; RA3 = 5'd3;
        expect_val(0, reset_cycle_exp, 28);
        expect_val(2, 32'h0, 29);
        step();
        idle_lanes();
        expect_val(0, 32'h77, 30);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            @(posedge reloj);
        end
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile_dual.md
# wb_regfile_dual

Write-back stage and architectural register file for the dual-issue pipeline, directly downstream of the MEM/WB pipeline register. Each of the two lanes selects its write-back value (data-memory output or ALU result) and commits it to a 32 x 32-bit register file on the clock edge. The file provides four combinational read ports to the decode stage, two per lane. It also exports the selected write-back values for forwarding into EX.

## Interface
Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.

Ports:
- reloj, in, 1, single clock; all state updates on posedge.
- resetWB, in, 1, synchronous, active-high reset.
- DIR_WB1 / DIR_WB2, in, 1, lane write-back select: 1 = DO_wb (load data), 0 = DIR_wb (ALU result).
- REG_WR1 / REG_WR2, in, 1, lane register-write enable.
- DO_wb1 / DO_wb2, in, 32, lane data-memory output.
- DIR_wb1 / DIR_wb2, in, 32, lane ALU result.
- Y_MUX_wb1 / Y_MUX_wb2, in, 5, lane destination register index.
- RA1, RA2, RA3, RA4, in, 5 each, read addresses (RA1/RA2 = lane 1 rs/rt, RA3/RA4 = lane 2 rs/rt).
- RD1, RD2, RD3, RD4, out, 32 each, read data.
- WD_wb1 / WD_wb2, out, 32, selected write-back value per lane (forwarding source).
- WE_eff1 / WE_eff2, out, 1, effective write enable per lane (REG_WR and index != 0, after conflict resolution).

## Operation
- Lane value: WD_wbN = DIR_WBN ? DO_wbN : DIR_wbN. This is purely combinational.
- Effective enables:
  - WE_eff1 = REG_WR1 & (Y_MUX_wb1 != 0) & ~(WE_eff2 & Y_MUX_wb1 == Y_MUX_wb2).
  - WE_eff2 = REG_WR2 & (Y_MUX_wb2 != 0).
- Same-destination conflict: lane 2 is the younger instruction, so lane 2 wins and lane 1's write is suppressed.
- Posedge reloj:
  - If resetWB, all registers are cleared to 0. Reset takes priority over any write in that cycle.
  - Otherwise, reg[Y_MUX_wbN] <= WD_wbN for each lane with WE_eff asserted.
- Reads are asynchronous: RDk = reg[RAk].
  - RAk == 0 always returns 0.
  - A write to index 0 never changes state.
- Reset values:
  - Every register is 0, so every RDk reads 0 after reset.
  - WD_wb and WE_eff have no reset value; they track their inputs combinationally.

## Timing
- Write latency: a value presented in cycle n is visible on RDk in cycle n+1 (without bypass).
- Read latency: 0 cycles, combinational from RAk and register state.
- Simultaneous write and read of the same index in one cycle:
  - Without bypass, RD returns the old value.
  - With bypass, see Configuration.
- Reset mid-stream: any write in the reset cycle is lost. The first write accepted is in the cycle after resetWB deasserts.
- No stalls or handshakes: the block commits whatever the MEM/WB register presents every cycle. Bubbles arrive with REG_WR = 0.

## Configuration
- Macro: WB_BYPASS_EN.
- Defined: write-through read. If a lane's WE_eff is set and its Y_MUX_wb matches RAk, RDk returns that lane's WD_wb in the same cycle. When both lanes match, lane 2 takes priority, consistent with conflict resolution. RAk == 0 still returns 0.
- Undefined: reads return stored register contents only. Decode must then tolerate the one-cycle write-to-read gap through hazard stalls.

## Structure
- Shared package: XLEN, NREG, register index width (5), and the named constant REG_ZERO = 0.
- Sub-module wb_lane_sel, instantiated once per lane, contains:
  - the DO/DIR mux producing WD_wb;
  - the raw enable qualification (REG_WR & index != 0).
- The top level holds:
  - the cross-lane conflict suppression;
  - the register array;
  - the four read ports with optional bypass.

## Test plan
- Reset: write x0A into r5, assert resetWB for 1 cycle, read RA1 = 5 -> RD1 = 0.
- Basic commit with mux select:
  - Lane 1: DIR_WB1 = 1, DO_wb1 = 0xDEADBEEF, DIR_wb1 = 0x1, Y_MUX_wb1 = 3, REG_WR1 = 1.
  - Lane 2: DIR_WB2 = 0, DIR_wb2 = 0x55, Y_MUX_wb2 = 4.
  - Next cycle: RD1(RA = 3) = 0xDEADBEEF and RD3(RA = 4) = 0x55.
- Conflict: both lanes write r7, lane 1 = 0x111 and lane 2 = 0x222 -> WE_eff1 = 0, WE_eff2 = 1, r7 = 0x222.
- Zero register: lane 2 writes 0xFFFFFFFF to index 0 with REG_WR2 = 1 -> WE_eff2 = 0, and reading RA4 = 0 gives 0.
- Same-cycle read of written index: lane 1 writes 0x42 to r9 while RA2 = 9.
  - Without WB_BYPASS_EN, RD2 = old value (0 after reset).
  - With WB_BYPASS_EN, RD2 = 0x42 in the same cycle.
- Write during reset: resetWB = 1 and REG_WR1 = 1 writing r2 = 0x77 -> after that edge r2 = 0. The same write repeated one cycle later lands (r2 = 0x77).
